half_adder: RTL and testbench



---
 rtl/half_adder_lane.sv | 12 +
 rtl/half_adder.sv | 69 ++++++
 tb/tb_half_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/half_adder_lane.sv
// Single-bit half adder cell: purely combinational sum/carry for one lane.
module half_adder_lane (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered multi-lane half adder with a valid flag and a sticky carry flag.
// All outputs come straight from flops; results appear one clock after sampling.
module half_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic             carry_seen
);

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (lane_sum[i]),
            .carry (lane_carry[i])
        );
    end

    // carry_seen folds in the incoming carry so it rises together with carry
    always_ff @(posedge clk) begin
        if (rst) begin
            sum        <= '0;
            carry      <= '0;
            out_valid  <= 1'b0;
            carry_seen <= 1'b0;
        end else begin
            sum        <= lane_sum;
            carry      <= lane_carry;
            out_valid  <= 1'b1;
            carry_seen <= carry_seen | (|lane_carry);
        end
    end

`ifdef FORMAL
    logic             f_past_rst;
    logic [WIDTH-1:0] f_a;
    logic [WIDTH-1:0] f_b;

    always_ff @(posedge clk) begin
        f_past_rst <= rst;
        f_a        <= a;
        f_b        <= b;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_formal_lane
        a_exclusive : assert property (@(posedge clk) out_valid |-> !(sum[i] && carry[i]));
        a_arith : assert property (@(posedge clk)
            out_valid |-> ({1'b0, sum[i]} + {carry[i], 1'b0}) == ({1'b0, f_a[i]} + {1'b0, f_b[i]}));
        c_row_00 : cover property (@(posedge clk) out_valid && !f_a[i] && !f_b[i]);
        c_row_01 : cover property (@(posedge clk) out_valid && !f_a[i] &&  f_b[i]);
        c_row_10 : cover property (@(posedge clk) out_valid &&  f_a[i] && !f_b[i]);
        c_row_11 : cover property (@(posedge clk) out_valid &&  f_a[i] &&  f_b[i]);
    end

    a_reset_clears : assert property (@(posedge clk)
        f_past_rst |-> (sum == '0 && carry == '0 && !out_valid && !carry_seen));
    c_seen_rise : cover property (@(posedge clk) !carry_seen ##1 carry_seen);
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: arithmetic reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_half_adder;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             out_valid;
    logic             carry_seen;

    int checks = 0;
    int errors = 0;

    half_adder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .carry      (carry),
        .out_valid  (out_valid),
        .carry_seen (carry_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-lane arithmetic addition, split into low bit and carry-out
    logic [WIDTH-1:0] exp_sum;
    logic [WIDTH-1:0] exp_carry;
    logic             exp_valid;
    logic             exp_seen;
    logic             known = 1'b0;

    always @(posedge clk) begin
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        int total;
        if (rst) begin
            exp_sum   <= '0;
            exp_carry <= '0;
            exp_valid <= 1'b0;
            exp_seen  <= 1'b0;
            known     <= 1'b1;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                total = int'(a[i]) + int'(b[i]);
                s[i]  = (total % 2) == 1;
                c[i]  = (total / 2) == 1;
            end
            exp_sum   <= s;
            exp_carry <= c;
            exp_valid <= 1'b1;
            exp_seen  <= exp_seen || (c != 0);
        end
    end

    always @(negedge clk) begin
        if (known) begin
            check("model_sum", 32'(sum), 32'(exp_sum));
            check("model_carry", 32'(carry), 32'(exp_carry));
            check("model_valid", 32'(out_valid), 32'(exp_valid));
            check("model_seen", 32'(carry_seen), 32'(exp_seen));
            check("exclusive", 32'(sum & carry), 32'd0);
        end
    end

    // Drive inputs, then wait past one rising edge to the following falling edge
    task automatic apply(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vr);
        a   = va;
        b   = vb;
        rst = vr;
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic [WIDTH-1:0] es, input logic [WIDTH-1:0] ec,
                       input logic ev, input logic esn);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_carry"}, 32'(carry), 32'(ec));
        check({name, "_valid"}, 32'(out_valid), 32'(ev));
        check({name, "_seen"}, 32'(carry_seen), 32'(esn));
    endtask

    initial begin
        // Reset with inputs that would otherwise carry
        apply(4'hF, 4'hF, 1'b1);
        pin("rst1", 4'h0, 4'h0, 1'b0, 1'b0);
        apply(4'hF, 4'hF, 1'b1);
        pin("rst2", 4'h0, 4'h0, 1'b0, 1'b0);

        // Truth-table sweep on lane 0
        apply(4'h0, 4'h0, 1'b0);
        pin("tt00", 4'h0, 4'h0, 1'b1, 1'b0);
        apply(4'h0, 4'h1, 1'b0);
        pin("tt01", 4'h1, 4'h0, 1'b1, 1'b0);
        apply(4'h1, 4'h0, 1'b0);
        pin("tt10", 4'h1, 4'h0, 1'b1, 1'b0);
        apply(4'h1, 4'h1, 1'b0);
        pin("tt11", 4'h0, 4'h1, 1'b1, 1'b1);

        // Sticky flag, then mid-run reset clears it
        apply(4'h0, 4'h1, 1'b0);
        pin("sticky", 4'h1, 4'h0, 1'b1, 1'b1);
        apply(4'h1, 4'h1, 1'b1);
        pin("midrst", 4'h0, 4'h0, 1'b0, 1'b0);
        apply(4'h1, 4'h0, 1'b0);
        pin("postrst", 4'h1, 4'h0, 1'b1, 1'b0);

        // Immediate carry right after reset release, held for two edges
        apply(4'h0, 4'h0, 1'b1);
        apply(4'h1, 4'h1, 1'b0);
        pin("imm1", 4'h0, 4'h1, 1'b1, 1'b1);
        apply(4'h1, 4'h1, 1'b0);
        pin("imm2", 4'h0, 4'h1, 1'b1, 1'b1);

        // Multi-lane pattern
        apply(4'h0, 4'h0, 1'b1);
        apply(4'b1100, 4'b1010, 1'b0);
        pin("multi", 4'b0110, 4'b1000, 1'b1, 1'b1);

        // Randomised run with occasional reset
        for (int n = 0; n < 1000; n++) begin
            apply(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
